// File: rtl/parity_serial_rx_if.sv
// Serial parity link, receive side: line inputs and recovered-word outputs.
interface parity_serial_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    // Line side / consumer: drives the strobe and line, observes the word
    modport master (
        output bit_en,
        output rx,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    // Receiver block
    modport slave (
        input  bit_en,
        input  rx,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/parity_serial_rx.sv
// Serial parity receiver: start bit, DATA_W data bits LSB first, one parity
// bit, one stop bit. Bit timing comes from the external bit_en strobe.
module parity_serial_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    parity_serial_rx_if.slave  bus
);
    localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
    localparam logic        ACC_INIT = (PARITY_ODD != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              acc;
    logic              perr;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;

    // Next shift-register value: new bit enters at the MSB so the first bit lands in bit 0
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shreg_next = bus.rx;
        end else begin : g_shift_many
            assign shreg_next = {bus.rx, shreg[DATA_W-1:1]};
        end
    endgenerate

    // Frame FSM and datapath, advancing only on bit_en strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            perr    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!bus.rx) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            acc     <= ACC_INIT;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= shreg_next;
                        acc     <= acc ^ bus.rx;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        perr  <= acc ^ bus.rx;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        data_q  <= shreg;
                        perr_q  <= perr;
                        ferr_q  <= ~bus.rx;
                        valid_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output mapping; busy reflects any non-idle state
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_parity_serial_rx.sv
// Bench for parity_serial_rx: one even-parity and one odd-parity receiver
// share the same line. Expected outputs are derived per frame from the word,
// parity bit and stop bit that the driver sends.
module tb_parity_serial_rx;
    logic clk = 1'b0;
    logic rst;
    logic bit_en;
    logic rx;

    always #5 clk = ~clk;

    parity_serial_rx_if #(.DATA_W(8)) bus_e ();
    parity_serial_rx_if #(.DATA_W(8)) bus_o ();

    assign bus_e.bit_en = bit_en;
    assign bus_e.rx     = rx;
    assign bus_o.bit_en = bit_en;
    assign bus_o.rx     = rx;

    parity_serial_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
        .clk (clk),
        .rst (rst),
        .bus (bus_e)
    );

    parity_serial_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
        .clk (clk),
        .rst (rst),
        .bus (bus_o)
    );

    // Expected outputs after the next rising edge
    logic       exp_busy;
    logic       exp_dv;
    logic [7:0] exp_data;
    logic       exp_pe_e;
    logic       exp_pe_o;
    logic       exp_fe;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned dv_cnt     = 0;
    bit          chk_en     = 1'b0;
    int unsigned gap_lo     = 0;
    int unsigned gap_hi     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both receivers against the frame-level expectations
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy_e", 32'(bus_e.busy), 32'(exp_busy));
            chk("busy_o", 32'(bus_o.busy), 32'(exp_busy));
            chk("dv_e", 32'(bus_e.data_valid), 32'(exp_dv));
            chk("dv_o", 32'(bus_o.data_valid), 32'(exp_dv));
            chk("data_e", 32'(bus_e.data_out), 32'(exp_data));
            chk("data_o", 32'(bus_o.data_out), 32'(exp_data));
            chk("perr_e", 32'(bus_e.parity_err), 32'(exp_pe_e));
            chk("perr_o", 32'(bus_o.parity_err), 32'(exp_pe_o));
            chk("ferr_e", 32'(bus_e.frame_err), 32'(exp_fe));
            chk("ferr_o", 32'(bus_o.frame_err), 32'(exp_fe));
            if (bus_e.data_valid === 1'b1) dv_cnt++;
        end
    end

    task automatic clear_exp();
        exp_busy = 1'b0;
        exp_dv   = 1'b0;
        exp_data = 8'h00;
        exp_pe_e = 1'b0;
        exp_pe_o = 1'b0;
        exp_fe   = 1'b0;
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        bit_en = 1'b0;
        rx     = 1'($urandom);
        exp_dv = 1'b0;
    endtask

    task automatic strobe(input logic b);
        int unsigned n;
        n = (gap_hi == 0) ? 0 : $urandom_range(gap_hi, gap_lo);
        repeat (n) gap_cycle();
        @(negedge clk);
        bit_en = 1'b1;
        rx     = b;
        exp_dv = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            bit_en = 1'b0;
            rx     = 1'b1;
            exp_dv = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        strobe(1'b0);
        exp_busy = 1'b1;
        for (int i = 0; i < 8; i++) strobe(d[i]);
        strobe(p);
        strobe(stop);
        exp_busy = 1'b0;
        exp_dv   = 1'b1;
        exp_data = d;
        exp_pe_e = (^d) ^ p;
        exp_pe_o = ~((^d) ^ p);
        exp_fe   = ~stop;
    endtask

    // Hand-computed values sampled right after a stop-bit edge
    task automatic pin(input logic [7:0] d, input logic pe_e, input logic pe_o, input logic fe);
        @(negedge clk);
        chk("pin_dv", 32'(bus_e.data_valid), 32'd1);
        chk("pin_busy", 32'(bus_e.busy), 32'd0);
        chk("pin_data", 32'(bus_e.data_out), 32'(d));
        chk("pin_pe_e", 32'(bus_e.parity_err), 32'(pe_e));
        chk("pin_pe_o", 32'(bus_o.parity_err), 32'(pe_o));
        chk("pin_fe", 32'(bus_e.frame_err), 32'(fe));
        bit_en = 1'b0;
        rx     = 1'b1;
        exp_dv = 1'b0;
    endtask

    initial begin
        int unsigned dv_before;
        logic [7:0]  rd;
        rst    = 1'b1;
        bit_en = 1'b0;
        rx     = 1'b1;
        clear_exp();
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus_e.busy), 32'd0);
        chk("rst_dv", 32'(bus_e.data_valid), 32'd0);
        chk("rst_data", 32'(bus_o.data_out), 32'd0);
        rst = 1'b0;

        // Idle strobes with line high must not start a frame
        repeat (3) strobe(1'b1);
        idle_cycles(2);

        send_frame(8'hA5, 1'b0, 1'b1);
        pin(8'hA5, 1'b0, 1'b1, 1'b0);

        send_frame(8'h01, 1'b0, 1'b1);
        pin(8'h01, 1'b1, 1'b0, 1'b0);

        // Stop bit 0, then a frame starting on the very next strobe
        send_frame(8'h3C, 1'b0, 1'b0);
        pin(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        pin(8'h5A, 1'b0, 1'b1, 1'b0);

        send_frame(8'h00, 1'b1, 1'b1);
        pin(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        pin(8'h00, 1'b0, 1'b1, 1'b0);

        // Reset after three data bits aborts the frame
        dv_before = dv_cnt;
        strobe(1'b0);
        exp_busy = 1'b1;
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'($urandom);
        rx     = 1'($urandom);
        clear_exp();
        @(negedge clk);
        rst    = 1'b0;
        bit_en = 1'b0;
        rx     = 1'b1;
        chk("abort_busy", 32'(bus_e.busy), 32'd0);
        chk("abort_data", 32'(bus_e.data_out), 32'd0);
        chk("abort_pe", 32'(bus_e.parity_err), 32'd0);
        chk("abort_nodv", 32'(dv_cnt), 32'(dv_before));
        send_frame(8'hC3, 1'b0, 1'b1);
        pin(8'hC3, 1'b0, 1'b1, 1'b0);

        // Gapped strobes with rx toggling in between, two frames back-to-back
        gap_lo    = 2;
        gap_hi    = 5;
        dv_before = dv_cnt;
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        pin(8'h80, 1'b0, 1'b1, 1'b0);
        chk("b2b_pulses", 32'(dv_cnt - dv_before), 32'd2);

        // Random frames: random word, parity bit, occasional bad stop, random gaps and idles
        gap_lo = 0;
        gap_hi = 3;
        for (int f = 0; f < 150; f++) begin
            rd = 8'($urandom);
            repeat ($urandom_range(2, 0)) strobe(1'b1);
            send_frame(rd, 1'($urandom), ($urandom_range(7, 0) != 0));
        end
        idle_cycles(4);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Receive end of the team's serial parity link. The transmitter XOR-folds a data word into one parity bit and sends the frame serially.
- This block rebuilds the word, recomputes the XOR parity across data and parity bits, and flags parity and framing errors.
- Sits between the line pin (already synchronised upstream) and the word consumer.
- Bit timing comes from an external one-cycle strobe, so the block contains no baud generator.

Parameters:
- DATA_W, 8, number of data bits per frame (range 1..32).
- PARITY_ODD, 0, 0 selects even parity and 1 selects odd parity.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  one-cycle strobe marking the sample point of each serial bit.
- rx  input  1  serial line; idles high.
- data_out  output  DATA_W  last received word; bit 0 is the first data bit on the line.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity result of the last completed frame.
- frame_err  output  1  stop-bit result of the last completed frame.
- busy  output  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, bit counter=0, shift register=0, parity accumulator=0.
- Reset has priority over every other input and aborts any frame in progress. No data_valid is produced for the aborted frame.
- rx is sampled only on cycles where bit_en=1. Cycles with bit_en=0 change nothing except clearing data_valid.
- Frame on the line: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
- State machine:
  - IDLE: bit_en and rx=0 -> DATA; clear counter; load accumulator with PARITY_ODD. bit_en and rx=1 -> stay in IDLE.
  - DATA: on each bit_en, shift rx in at the MSB and shift right, so the first bit ends up in bit 0; accumulator ^= rx; counter++. After the DATA_W-th bit -> PAR.
  - PAR: on bit_en, latch perr = accumulator ^ rx. perr=1 means the data and parity bits do not satisfy the selected parity. -> STOP.
  - STOP: on bit_en, in the same edge:
    - data_out <= shift register.
    - parity_err <= perr.
    - frame_err <= ~rx.
    - data_valid <= 1.
    - state -> IDLE.
- data_valid:
  - Rises on the clock edge that samples the stop bit and is high for exactly one cycle.
  - Asserted even when parity_err or frame_err is set.
- data_out, parity_err and frame_err hold their values until the next frame completes.
- Latency: outputs are valid one clk after the stop-bit bit_en cycle.
- Frame error: a stop bit of 0 does not count as a new start bit. The state returns to IDLE and the next bit_en with rx=0 starts a new frame.
- Back-to-back frames: a start bit on the bit_en immediately after the stop bit is accepted with no idle bit in between.
- busy: asserted from the clock after start-bit detection until the clock after the stop-bit sample.
- Counter width is clog2(DATA_W+1). The counter does not wrap within a frame.

Test Plan:
- DATA_W=8, even parity. Send frame 0xA5: start 0; bits 1,0,1,0,0,1,0,1; parity 0; stop 1 -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy falls after the stop bit.
- Send 0x01 with parity 0 (wrong for even) -> data_out=0x01, parity_err=1, frame_err=0, data_valid pulses.
- Send 0x3C with correct parity 0 and stop bit 0 -> frame_err=1, parity_err=0. Then a valid frame 0x5A -> data_out=0x5A, frame_err=0.
- PARITY_ODD=1. Send 0x00 with parity 1 -> parity_err=0. Send 0x00 with parity 0 -> parity_err=1.
- Assert rst for one cycle after 3 data bits of a frame -> busy=0, no data_valid, all outputs 0. The next clean frame 0xC3 is received correctly.
- Insert 2-5 cycles of bit_en=0 between bits while toggling rx randomly, and send two frames (0xFF, 0x80) back-to-back -> rx is ignored whenever bit_en=0, exactly two data_valid pulses, data_out=0xFF then 0x80, no errors.
